// File: rtl/parity_ser_tx_pkg.sv
// Shared definitions for the parity serial transmitter.
//   tx_state_e : frame sequencing states
//   START_BIT / STOP_BIT / IDLE_LVL : serial line levels
//   CNT_W      : width of the per-bit cycle counter (BIT_CYC up to 255)
//   frame_len  : clocks from first start-bit cycle to last stop-bit cycle
package parity_ser_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam int unsigned CNT_W = 8;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned bit_cyc);
    return (data_w + 3) * bit_cyc;
  endfunction

endpackage

// File: rtl/parity_ser_tx_bit_timer.sv
// Per-bit cycle timer for the serial transmitter.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   restart_i  : clear the count (asserted on every state change)
//   bit_tick_o : high in the last cycle of the current bit period
module parity_ser_tx_bit_timer
  import parity_ser_tx_pkg::*;
#(
  parameter int unsigned BIT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_tick_o
);

  logic [CNT_W-1:0] cyc_cnt_q;
  logic [CNT_W-1:0] cyc_cnt_d;

  assign bit_tick_o = (cyc_cnt_q == CNT_W'(BIT_CYC - 1));

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    if (restart_i || bit_tick_o) begin
      cyc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

endmodule

// File: rtl/parity_ser_tx.sv
// Serial transmit stage for parity-protected words.
// Frame on tx: start bit, DATA_W data bits LSB-first, par_in as-is, stop bit,
// each bit held BIT_CYC clocks. All outputs are registered.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   din       : word to send, captured on handshake
//   par_in    : check bit, captured with din
//   din_valid : upstream word available
//   din_ready : high only while idle
//   tx        : serial line, idles high
//   busy      : frame in progress
//   done      : one-cycle pulse on the first idle cycle after a frame
module parity_ser_tx
  import parity_ser_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BIT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              par_in,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              par_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              ready_q;

  logic accept;
  logic last_bit;
  logic bit_tick;
  logic restart;

  assign din_ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    accept   = din_valid && ready_q;
    last_bit = (bit_idx_q == IDX_W'(DATA_W - 1));
    // Every bit-period end outside IDLE changes state, except inside the
    // data bits where only the last one moves on to PARITY.
    restart  = accept ||
               (bit_tick && (state_q != IDLE) &&
                !((state_q == DATA) && !last_bit));
  end

  parity_ser_tx_bit_timer #(
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (restart),
    .bit_tick_o (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            shift_q   <= din;
            par_q     <= par_in;
            bit_idx_q <= '0;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q <= shift_q >> 1;
            if (last_bit) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              // tx is registered, so drive the bit that shift_q[0] is about
              // to hold after this shift.
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            tx_q    <= STOP_BIT;
          end
        end
        STOP: begin
          if (bit_tick) begin
            state_q <= IDLE;
            tx_q    <= IDLE_LVL;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LVL;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
